// File: rtl/seg_scan_bcd_if.sv
// seg_scan_bcd_if: ALU-side load/busy bundle for the display back-end.
// Carries hex_sel only when SEG_SCAN_HEX_MODE_EN is defined.
interface seg_scan_bcd_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] value;
  logic              neg;
  logic              load;
  logic              busy;
`ifdef SEG_SCAN_HEX_MODE_EN
  logic              hex_sel;

  modport master (
    output value, neg, load, hex_sel,
    input  busy
  );

  modport slave (
    input  value, neg, load, hex_sel,
    output busy
  );
`else
  modport master (
    output value, neg, load,
    input  busy
  );

  modport slave (
    input  value, neg, load,
    output busy
  );
`endif
endinterface

// File: rtl/seg_scan_bcd.sv
// seg_scan_bcd: double-dabble binary-to-BCD plus 7-seg anode scan.
// Optional raw-hex display path enabled by SEG_SCAN_HEX_MODE_EN.
module seg_scan_bcd #(
  parameter int DATA_W     = 8,
  parameter int BCD_DIGITS = 3,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000
) (
  input  logic          CLK100MHZ,
  input  logic          rst,
  seg_scan_bcd_if.slave bus,
  input  logic          DispCont,
  output logic [7:0]    AN,
  output logic [6:0]    seg
);
  localparam int HEX_N = (DATA_W + 3) / 4;
  localparam int DISP_N =
    (BCD_DIGITS > HEX_N) ? BCD_DIGITS : HEX_N;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int DW = 4 * DISP_N;
  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     adj;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              neg_lat_q, neg_lat_d;
  logic              hex_q, hex_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic              disp_neg_q, disp_neg_d;
  logic [CW-1:0]     scan_q, scan_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              hex_req;
  logic [3:0]        dig;
  logic [6:0]        code;
  logic              blank;
  int                msd;

`ifdef SEG_SCAN_HEX_MODE_EN
  assign hex_req = bus.hex_sel;
`else
  assign hex_req = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign AN       = an_q;
  assign seg      = seg_q;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Conversion FSM state register
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = hex_req ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == NW'(DATA_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath: latch, add-3/shift, commit to display
  always_comb begin
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_lat_d  = neg_lat_q;
    hex_d      = hex_q;
    disp_d     = disp_q;
    disp_neg_d = disp_neg_q;
    adj        = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          sh_d      = bus.value;
          neg_lat_d = bus.neg;
          hex_d     = hex_req;
          bcd_d     = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        bcd_d = {adj[BW-2:0], sh_q[DATA_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
      end
      COMMIT: begin
        disp_d = '0;
        if (hex_q) begin
          disp_d[DATA_W-1:0] = sh_q;
        end else begin
          disp_d[BW-1:0] = bcd_q;
        end
        disp_neg_d = neg_lat_q & ~hex_q;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scan timing and slot formatting
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    msd = 0;
    dig = '0;
    for (int i = 0; i < DISP_N; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) begin
        msd = i;
      end
      if (int'(idx_q) == i) begin
        dig = disp_q[4*i +: 4];
      end
    end
    blank = 1'b0;
    if (int'(idx_q) <= msd) begin
      code = seg_of(dig);
    end else if (disp_neg_q && (|disp_q) &&
                 int'(idx_q) == msd + 1) begin
      code = 7'h3F;
    end else begin
      code  = 7'h7F;
      blank = 1'b1;
    end
    seg_d = code;
    if (scan_q == '0 || !DispCont || blank) begin
      an_d = 8'hFF;
    end else begin
      an_d = ~(8'h01 << idx_q);
    end
  end

  // Datapath, display and pin registers
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_lat_q  <= 1'b0;
      hex_q      <= 1'b0;
      busy_q     <= 1'b0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_lat_q  <= neg_lat_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
      disp_q     <= disp_d;
      disp_neg_q <= disp_neg_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end
endmodule

// File: doc/seg_scan_bcd.md
Name: seg_scan_bcd

Overview:
- Display back-end for the 4-bit ALU board design: takes a binary result from the ALU datapath, converts it to decimal sequentially, and drives the multiplexed 8-digit seven-segment display.
- Conversion uses iterative double-dabble, one shift per clock.
- The display is refreshed by a time-multiplexed anode scan.
- Sits directly downstream of the ALU stage and owns the AN/seg pins.

Parameters:
- DATA_W, 8: width of the unsigned magnitude input.
- BCD_DIGITS, 3: decimal digits produced. Must satisfy 10^BCD_DIGITS > 2^DATA_W - 1.
- NUM_DIGITS, 4: anodes actually scanned, AN[0]..AN[NUM_DIGITS-1]. Must be >= BCD_DIGITS+1 and <= 8.
- SCAN_DIV, 100000: clocks per digit slot (1 kHz per digit at 100 MHz). Must be >= 2.

Ports:
- CLK100MHZ  in   1  system clock.
- rst  in  1  synchronous reset, active-high.
- value  in  DATA_W  unsigned magnitude to display.
- neg  in  1  sign flag; 1 shows a minus sign.
- load  in  1  single-cycle strobe; samples value/neg when accepted.
- DispCont  in  1  display enable; 0 blanks all anodes.
- busy  out  1  conversion in progress; load is ignored while high.
- AN  out  8  anodes, active-low; AN[7:NUM_DIGITS] are held at 1.
- seg  out  7  cathodes, active-low, seg[0]=CA … seg[6]=CG.

Behaviour:
- Clocking and reset: single clock domain. All outputs are registered. Synchronous active-high reset.
- Reset values:
  - AN=8'hFF, seg=7'h7F, busy=0.
  - Display register = value 0, neg 0.
  - Scan counter and digit index = 0.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: when load=1, latch value into the shift register, latch neg, clear the BCD accumulator, and go to SHIFT. busy rises the next cycle.
  - SHIFT: runs exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit with the MSB of value entering the BCD LSB.
  - COMMIT: runs 1 cycle. Copies the BCD digits and neg into the display register, then returns to IDLE. busy falls on the cycle after COMMIT.
  - Total: busy is high for DATA_W+1 cycles. The new digits are visible at the next scan slot of each digit.
- load while busy: ignored, with no queuing.
- Reset mid-conversion: aborts immediately. The display returns to "0" and any partial result is discarded.
- Digit formatting:
  - Leading-zero blanking: digits above the most significant non-zero digit are blanked. Digit 0 always shows, so value 0 displays "0".
  - Minus sign (seg=7'h3F) goes in the slot immediately left of the most significant shown digit.
  - neg=1 with value 0 shows "0" with no sign.
  - Slots above the sign are blank.
- Segment codes (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On terminal count it wraps and the digit index increments modulo NUM_DIGITS.
  - AN[idx]=0 only if DispCont=1 and the slot is not blank. Otherwise all AN are 1.
  - AN and seg are registered together, so they never mismatch by a cycle.
  - On AN transitions, AN goes to all 1 for the first cycle of each slot (ghosting guard). seg is updated in that same cycle.
- DispCont=0 does not stop conversion or the scan counter; it only forces AN=8'hFF.

Optional Feature:
- Macro: SEG_SCAN_HEX_MODE_EN.
- When defined:
  - Adds input port hex_sel (1 bit).
  - A load with hex_sel=1 skips SHIFT: it goes IDLE→COMMIT directly, so busy is high 1 cycle.
  - Raw nibbles of value are displayed as hex (A=08, b=03, C=46, d=21, E=06, F=0E), using ceil(DATA_W/4) digits.
  - neg is ignored and leading-zero blanking still applies.
- When undefined: the port is absent and behaviour is decimal only.

Test Plan:
1. Reset (SCAN_DIV=4 for all sims): assert rst 3 cycles → AN=FF, seg=7F, busy=0. After release, slot 0 shows seg=40 with AN=FE; slots 1–3 stay blank (AN=FF).
2. load value=255, neg=0 → busy high exactly 9 cycles. Scan slots then show digit0=12, digit1=12, digit2=24 ("255"); slot 3 is blank.
3. load value=7, neg=1 → slot0=78, slot1=3F, slots 2–3 blank. Then load value=0, neg=1 → only slot0=40 shows, with no minus.
4. Pulse load with value=99 at cycle 3 of a conversion of 128 → the load is ignored and the display shows "128" (slot0=00, slot1=24, slot2=79).
5. DispCont=0 during scan → AN=FF every cycle while the scan counter keeps advancing. Raising DispCont resumes at the current digit index.
6. Assert rst at cycle 4 of SHIFT → busy=0 and the display shows "0" next slot. A subsequent load 42 displays "42" (slot0=24, slot1=19).
   - With SEG_SCAN_HEX_MODE_EN: hex_sel=1, value=8'hAF → slot0=0E, slot1=08, busy high 1 cycle.
